// File: rtl/dieu_khien_den.sv
// Highway / country-road traffic light controller with BCD countdowns.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   tick        - one-clk-wide pulse per second, synchronous to clk
//   car_cr      - country-road vehicle sensor (asynchronous)
//   count_h     - highway countdown, BCD {tens, units}
//   count_cr    - country-road countdown, BCD {tens, units}
//   color_h     - highway light code (1 red, 2 yellow, 3 green)
//   color_cr    - country-road light code
module dieu_khien_den #(
    parameter int unsigned T_HG = 25,
    parameter int unsigned T_CG = 15,
    parameter int unsigned T_Y  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       car_cr,
    output logic [7:0] count_h,
    output logic [7:0] count_cr,
    output logic [2:0] color_h,
    output logic [2:0] color_cr
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CLR_W = 3;

    localparam logic [CLR_W-1:0] RED    = CLR_W'(1);
    localparam logic [CLR_W-1:0] YELLOW = CLR_W'(2);
    localparam logic [CLR_W-1:0] GREEN  = CLR_W'(3);

    // Reject timings the two-digit BCD counters cannot represent.
    if (T_Y == 0 || T_HG < 2 || T_CG < 2 || (T_HG + T_Y) > 99 || (T_CG + T_Y) > 99) begin : g_bad_param
        $error("dieu_khien_den: timing parameters out of range");
    end

    function automatic logic [CNT_W-1:0] to_bcd(input int unsigned v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    // BCD decrement with borrow from tens into units.
    function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] v);
        if (v[3:0] == 4'd0) begin
            bcd_dec = {v[7:4] - 4'd1, 4'd9};
        end else begin
            bcd_dec = {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    localparam logic [CNT_W-1:0] BCD_HG    = to_bcd(T_HG);
    localparam logic [CNT_W-1:0] BCD_HG_Y  = to_bcd(T_HG + T_Y);
    localparam logic [CNT_W-1:0] BCD_CG    = to_bcd(T_CG);
    localparam logic [CNT_W-1:0] BCD_CG_Y  = to_bcd(T_CG + T_Y);
    localparam logic [CNT_W-1:0] BCD_Y     = to_bcd(T_Y);
    localparam logic [CNT_W-1:0] BCD_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HG = 2'd0,
        ST_HY = 2'd1,
        ST_CG = 2'd2,
        ST_CY = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] count_h_q,  count_h_d;
    logic [CNT_W-1:0] count_cr_q, count_cr_d;
    logic [CLR_W-1:0] color_h_q,  color_h_d;
    logic [CLR_W-1:0] color_cr_q, color_cr_d;
    logic             car_meta_q;
    logic             car_s_q;
    logic             run_q;
    logic             tick_ok;
    logic [CNT_W-1:0] active_cnt;

    // run_q masks a tick landing in the same cycle reset is released.
    assign tick_ok    = tick & run_q;
    assign active_cnt = (state_q == ST_HG || state_q == ST_HY) ? count_h_q : count_cr_q;

    // Next-state, counter and light computation.
    always_comb begin
        state_d    = state_q;
        count_h_d  = count_h_q;
        count_cr_d = count_cr_q;
        color_h_d  = GREEN;
        color_cr_d = RED;

        if (tick_ok) begin
            if (active_cnt > BCD_ONE) begin
                count_h_d  = bcd_dec(count_h_q);
                count_cr_d = bcd_dec(count_cr_q);
            end else begin
                case (state_q)
                    ST_HG: begin
                        // Highway keeps green at 01 until a car is waiting.
                        if (car_s_q) begin
                            state_d    = ST_HY;
                            count_h_d  = BCD_Y;
                            count_cr_d = BCD_Y;
                        end
                    end
                    ST_HY: begin
                        state_d    = ST_CG;
                        count_h_d  = BCD_CG_Y;
                        count_cr_d = BCD_CG;
                    end
                    ST_CG: begin
                        state_d    = ST_CY;
                        count_h_d  = BCD_Y;
                        count_cr_d = BCD_Y;
                    end
                    ST_CY: begin
                        state_d    = ST_HG;
                        count_h_d  = BCD_HG;
                        count_cr_d = BCD_HG_Y;
                    end
                    default: state_d = ST_HG;
                endcase
            end
        end

        case (state_d)
            ST_HG:   begin color_h_d = GREEN;  color_cr_d = RED;    end
            ST_HY:   begin color_h_d = YELLOW; color_cr_d = RED;    end
            ST_CG:   begin color_h_d = RED;    color_cr_d = GREEN;  end
            ST_CY:   begin color_h_d = RED;    color_cr_d = YELLOW; end
            default: begin color_h_d = GREEN;  color_cr_d = RED;    end
        endcase
    end

    // State, counters, lights and sensor synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HG;
            count_h_q  <= BCD_HG;
            count_cr_q <= BCD_HG_Y;
            color_h_q  <= GREEN;
            color_cr_q <= RED;
            car_meta_q <= 1'b0;
            car_s_q    <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_h_q  <= count_h_d;
            count_cr_q <= count_cr_d;
            color_h_q  <= color_h_d;
            color_cr_q <= color_cr_d;
            car_meta_q <= car_cr;
            car_s_q    <= car_meta_q;
            run_q      <= 1'b1;
        end
    end

    assign count_h  = count_h_q;
    assign count_cr = count_cr_q;
    assign color_h  = color_h_q;
    assign color_cr = color_cr_q;

endmodule

// File: tb/tb_dieu_khien_den.sv
// Self-checking bench for dieu_khien_den: a decimal reference model pushes
// expected outputs into a scoreboard on each tick; they are popped and
// compared on the following falling edge.
module tb_dieu_khien_den;

    localparam int unsigned T_HG = 25;
    localparam int unsigned T_CG = 15;
    localparam int unsigned T_Y  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       car_cr = 1'b0;
    logic [7:0] count_h;
    logic [7:0] count_cr;
    logic [2:0] color_h;
    logic [2:0] color_cr;

    dieu_khien_den #(.T_HG(T_HG), .T_CG(T_CG), .T_Y(T_Y)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .car_cr   (car_cr),
        .count_h  (count_h),
        .count_cr (count_cr),
        .color_h  (color_h),
        .color_cr (color_cr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state 0..3 = HG, HY, CG, CY; counters in decimal.
    int m_st;
    int m_h;
    int m_cr;
    bit m_car;

    logic [21:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [21:0] model_out();
        logic [2:0] ch;
        logic [2:0] ccr;
        case (m_st)
            0:       begin ch = 3'd3; ccr = 3'd1; end
            1:       begin ch = 3'd2; ccr = 3'd1; end
            2:       begin ch = 3'd1; ccr = 3'd3; end
            default: begin ch = 3'd1; ccr = 3'd2; end
        endcase
        return {ch, ccr, bcd(m_h), bcd(m_cr)};
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_h  = T_HG;
        m_cr = T_HG + T_Y;
    endtask

    task automatic model_tick();
        int act;
        act = (m_st < 2) ? m_h : m_cr;
        if (act > 1) begin
            m_h--;
            m_cr--;
        end else begin
            case (m_st)
                0: if (m_car) begin m_st = 1; m_h = T_Y; m_cr = T_Y; end
                1: begin m_st = 2; m_h = T_CG + T_Y; m_cr = T_CG; end
                2: begin m_st = 3; m_h = T_Y; m_cr = T_Y; end
                default: begin m_st = 0; m_h = T_HG; m_cr = T_HG + T_Y; end
            endcase
        end
    endtask

    task automatic compare_out(input string tag, input logic [21:0] e);
        check({tag, "_color_h"},  32'(color_h),  32'(e[21:19]));
        check({tag, "_color_cr"}, 32'(color_cr), 32'(e[18:16]));
        check({tag, "_count_h"},  32'(count_h),  32'(e[15:8]));
        check({tag, "_count_cr"}, 32'(count_cr), 32'(e[7:0]));
    endtask

    // One tick pulse; expectation queued at drive time, compared after the edge.
    task automatic tick_once(input string tag);
        logic [21:0] e;
        @(negedge clk);
        tick = 1'b1;
        model_tick();
        sb.push_back(model_out());
        @(negedge clk);
        tick = 1'b0;
        e = sb.pop_front();
        compare_out(tag, e);
    endtask

    // Asynchronous reset pulse, asserted away from any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_out(tag, model_out());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_car(input bit v);
        @(negedge clk);
        car_cr = v;
        m_car  = v;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        m_car = 1'b0;
        model_reset();

        // Reset values against literal constants.
        repeat (2) @(negedge clk);
        check("rst_count_h",  32'(count_h),  32'h25);
        check("rst_count_cr", 32'(count_cr), 32'h28);
        check("rst_color_h",  32'(color_h),  32'd3);
        check("rst_color_cr", 32'(color_cr), 32'd1);
        rst_n = 1'b1;

        // Highway hold with no car, then release.
        set_car(1'b0);
        for (int i = 0; i < 30; i++) tick_once("hold");
        check("hold_count_h",  32'(count_h),  32'h01);
        check("hold_count_cr", 32'(count_cr), 32'h04);
        check("hold_color_h",  32'(color_h),  32'd3);
        set_car(1'b1);
        tick_once("release");
        check("release_count_h",  32'(count_h),  32'h03);
        check("release_count_cr", 32'(count_cr), 32'h03);
        check("release_color_h",  32'(color_h),  32'd2);

        // Full cycle from reset with a car always waiting.
        do_reset("rst_full");
        for (int i = 0; i < 46; i++) begin
            if (m_st == 2 && m_cr == 10) begin
                tick_once("borrow");
                check("borrow_count_cr", 32'(count_cr), 32'h09);
                check("borrow_count_h",  32'(count_h),  32'h12);
            end else begin
                tick_once("full");
            end
        end
        check("full_end_count_h",  32'(count_h),  32'h25);
        check("full_end_count_cr", 32'(count_cr), 32'h28);
        check("full_end_color_h",  32'(color_h),  32'd3);
        check("full_end_color_cr", 32'(color_cr), 32'd1);

        // Reset in the middle of country-road green.
        for (int i = 0; i < 100 && !(m_st == 2 && m_cr == 7); i++) tick_once("to_cg");
        check("mid_in_cg", 32'(count_cr), 32'h07);
        do_reset("rst_mid");
        tick_once("after_mid");
        check("after_mid_count_h",  32'(count_h),  32'h24);
        check("after_mid_count_cr", 32'(count_cr), 32'h27);

        // Idle: no ticks, sensor toggling.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            car_cr = 1'($urandom_range(0, 1));
            compare_out("idle", model_out());
        end
        set_car(1'b1);

        // Tick coinciding with reset release is ignored.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        compare_out("rel_tick", model_out());
        tick_once("rel_next");
        check("rel_next_count_h", 32'(count_h), 32'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
